seq_shifter_4bit: RTL and testbench



---
 rtl/seq_shifter_4bit_pkg.sv | 22 ++
 rtl/seq_shifter_4bit_shift_step.sv | 31 +++
 rtl/seq_shifter_4bit.sv | 102 ++++++++++
 tb/tb_seq_shifter_4bit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_4bit_pkg.sv
// ---------------------------------------------------------------------------
// seq_shifter_4bit_pkg
// Shared constants for the iterative shifter, barrel_shifter_4bit and the
// benches that compare them: default widths, FSM state encodings and the
// direction encoding.
// ---------------------------------------------------------------------------
package seq_shifter_4bit_pkg;

  // Default data width and shift-amount width
  localparam int WIDTH_DEFAULT = 4;
  localparam int SHW_DEFAULT   = 2;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Shift direction encoding
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : seq_shifter_4bit_pkg

// File: rtl/seq_shifter_4bit_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-position logical shifter with zero fill.
// Also usable as one stage of a barrel shifter.
//
// Ports:
//   d    in   WIDTH  operand
//   dir  in   1      DIR_LEFT (0) or DIR_RIGHT (1)
//   q    out  WIDTH  d shifted by one position in direction dir
// ---------------------------------------------------------------------------
module shift_step
  import seq_shifter_4bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  // Vacated bit position is always filled with zero (logical shift)
  always_comb begin
    q = '0;
    if (dir == DIR_RIGHT) begin
      q = {1'b0, d[WIDTH-1:1]};
    end else begin
      q = {d[WIDTH-2:0], 1'b0};
    end
  end

endmodule : shift_step

// File: rtl/seq_shifter_4bit.sv
// ---------------------------------------------------------------------------
// seq_shifter_4bit
// Iterative logical shifter: one bit position per clock, under a
// start/busy/done handshake.  Produces the same result as the combinational
// barrel_shifter_4bit for identical A/sel/dir.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request, accepted only in IDLE
//   A      in   WIDTH  operand, sampled on accept
//   sel    in   SHW    shift amount, sampled on accept
//   dir    in   1      0 = left, 1 = right, sampled on accept
//   busy   out  1      high from accept until return to IDLE
//   done   out  1      one-cycle pulse, out holds the result
//   out    out  WIDTH  registered result, held until the next result
// ---------------------------------------------------------------------------
module seq_shifter_4bit
  import seq_shifter_4bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHW   = SHW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   sel,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_step;

  // Single shift stage shared by every SHIFT cycle
  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d   (r_data),
    .dir (r_dir),
    .q   (w_step)
  );

  // Control FSM and datapath.  out is written only on the edge that enters
  // DONE, so intermediate shift values never become visible.  Amounts of
  // WIDTH or more naturally yield zero after WIDTH steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data <= A;
            r_cnt  <= sel;
            r_dir  <= dir;
            if (sel == '0) begin
              r_state <= ST_DONE;
              r_out   <= A;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_step;
          r_cnt  <= r_cnt - SHW'(1);
          // Last step: the freshly shifted value is the result
          if (r_cnt == SHW'(1)) begin
            r_state <= ST_DONE;
            r_out   <= w_step;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state
  always_comb begin
    busy = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
    out  = r_out;
  end

endmodule : seq_shifter_4bit

// File: tb/tb_seq_shifter_4bit.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter_4bit
// Self-checking bench for seq_shifter_4bit: a table of operations with
// known results, plus hand-written sequences for ignored starts, reset in
// the middle of an operation and back-to-back operations with start held.
// A reference model predicts acceptance, busy, done timing and results.
// ---------------------------------------------------------------------------
module tb_seq_shifter_4bit;
  import seq_shifter_4bit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = 4'b0000;
  logic [1:0] sel = 2'b00;
  logic       dir = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] outVal;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] res;
    int         doneCyc;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [1:0] sel;
    logic       dir;
    logic [3:0] expOut;
  } vec_t;

  exp_t       sb[$];
  exp_t       newExp;
  int         cyc = 0;
  int         modelFree = 0;
  logic [3:0] expOutHeld = 4'b0000;
  bit         monEn = 1'b0;
  vec_t       vecs[10];

  seq_shifter_4bit #(
    .WIDTH (4),
    .SHW   (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .sel   (sel),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .out   (outVal)
  );

  always #5 clk = ~clk;

  // Reference result: shift one position at a time with zero fill
  function automatic logic [3:0] barrelRef(logic [3:0] v, logic [1:0] n, logic d);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < int'(n); i++) begin
      if (d) r = {1'b0, r[3:1]};
      else   r = {r[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model (rising edge) and scoreboard monitor (falling edge).
  // An operation accepted at edge n is busy for intervals n..n+sel, pulses
  // done in interval n+sel and frees the FSM for a new accept at n+sel+2.
  always @(posedge clk or negedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      modelFree  = 0;
      expOutHeld = 4'b0000;
    end else if (clk) begin
      cyc++;
      if (start && cyc >= modelFree) begin
        newExp.res     = barrelRef(a, sel, dir);
        newExp.doneCyc = cyc + int'(sel);
        sb.push_back(newExp);
        modelFree = cyc + int'(sel) + 2;
      end
    end else if (monEn) begin
      checkOutput("mon_busy", int'(busy), int'(sb.size() > 0));
      checkOutput("mon_done", int'(done), int'(sb.size() > 0 && sb[0].doneCyc == cyc));
      if (sb.size() > 0 && sb[0].doneCyc == cyc) begin
        expOutHeld = sb[0].res;
        void'(sb.pop_front());
      end
      checkOutput("mon_out", int'(outVal), int'(expOutHeld));
    end
  end

  // Wait (bounded) until done is seen on a falling edge; lat counts the
  // falling edges observed, starting at 1 for the edge we are on now
  task automatic waitDone(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout", int'(done), 1);
  endtask

  // Pulse start for one cycle with the given operands, then wait for done
  task automatic applyStimulus(input logic [3:0] va, input logic [1:0] vs,
                               input logic vd, output int lat);
    @(negedge clk);
    a     = va;
    sel   = vs;
    dir   = vd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n;

    vecs[0] = '{4'b1011, 2'd1, DIR_LEFT,  4'b0110};
    vecs[1] = '{4'b1011, 2'd2, DIR_LEFT,  4'b1100};
    vecs[2] = '{4'b1011, 2'd1, DIR_RIGHT, 4'b0101};
    vecs[3] = '{4'b1011, 2'd2, DIR_RIGHT, 4'b0010};
    vecs[4] = '{4'b1011, 2'd0, DIR_LEFT,  4'b1011};
    vecs[5] = '{4'b1011, 2'd0, DIR_RIGHT, 4'b1011};
    vecs[6] = '{4'b1011, 2'd3, DIR_LEFT,  4'b1000};
    vecs[7] = '{4'b1011, 2'd3, DIR_RIGHT, 4'b0001};
    vecs[8] = '{4'b0110, 2'd1, DIR_RIGHT, 4'b0011};
    vecs[9] = '{4'b0101, 2'd3, DIR_RIGHT, 4'b0000};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_out", int'(outVal), 0);
    rst = 1'b0;
    monEn = 1'b1;

    // Table of single operations: result and latency sel+1
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].sel, vecs[i].dir, lat);
      checkOutput($sformatf("vec%0d_out", i), int'(outVal), int'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d_latency", i), lat, int'(vecs[i].sel) + 1);
    end

    // Start during SHIFT is ignored and not queued
    @(negedge clk);
    a = 4'b1011; sel = 2'd2; dir = DIR_LEFT; start = 1'b1;
    @(negedge clk);
    a = 4'b0001; sel = 2'd1; dir = DIR_RIGHT;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("ignore_out", int'(outVal), 4'b1100);
    countDones(6, n);
    checkOutput("ignore_extra_done", n, 0);

    // Asynchronous reset during the second SHIFT cycle
    @(negedge clk);
    a = 4'b1111; sel = 2'd3; dir = DIR_LEFT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_out", int'(outVal), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    countDones(8, n);
    checkOutput("midreset_no_done", n, 0);
    applyStimulus(4'b1011, 2'd1, DIR_LEFT, lat);
    checkOutput("after_reset_out", int'(outVal), 4'b0110);
    checkOutput("after_reset_latency", lat, 2);

    // Start held high: re-accepted every sel+2 cycles
    @(negedge clk);
    a = 4'b0110; sel = 2'd1; dir = DIR_RIGHT; start = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        n++;
        checkOutput("hold_out", int'(outVal), 4'b0011);
      end
    end
    start = 1'b0;
    checkOutput("hold_dones", n, 3);
    @(negedge clk);
    waitDone(lat);
    checkOutput("hold_last_out", int'(outVal), 4'b0011);
    countDones(5, n);
    checkOutput("hold_drained", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_shifter_4bit
